// File: rtl/choice_update_scheduler_pkg.sv
// Shared types for the choice-table scheduler: history width and the queued update record.
// No logic; imported by the interface, the update FIFO and the top level.
package choice_update_scheduler_pkg;

    localparam int HIST_W = 12;

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              dir;
    } choice_upd_t;

endpackage

// File: rtl/choice_update_scheduler_if.sv
// Front-end, resolve and table-port signals of the choice scheduler.
// master = surrounding pipeline/table, slave = the scheduler.
interface choice_update_scheduler_if
    import choice_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              lookup_valid;
    logic              lookup_ready;
    logic              lookup_pred_tkn;
    logic [HIST_W-1:0] lookup_hist;
    logic              resolve_valid;
    logic              resolve_ready;
    logic [HIST_W-1:0] resolve_hist;
    logic              resolve_taken;
    logic              resolve_mispred;
    logic              local_correct;
    logic              global_correct;
    logic              tbl_en;
    logic              tbl_we;
    logic [HIST_W-1:0] tbl_addr;
    logic              tbl_favor_glb;
    logic [HIST_W-1:0] phist;
    logic [CW-1:0]     q_count;

    modport master (
        output lookup_valid, lookup_pred_tkn,
        output resolve_valid, resolve_hist, resolve_taken, resolve_mispred,
        output local_correct, global_correct,
        input  lookup_ready, lookup_hist, resolve_ready,
        input  tbl_en, tbl_we, tbl_addr, tbl_favor_glb, phist, q_count
    );

    modport slave (
        input  lookup_valid, lookup_pred_tkn,
        input  resolve_valid, resolve_hist, resolve_taken, resolve_mispred,
        input  local_correct, global_correct,
        output lookup_ready, lookup_hist, resolve_ready,
        output tbl_en, tbl_we, tbl_addr, tbl_favor_glb, phist, q_count
    );

endinterface

// File: rtl/choice_update_scheduler_fifo.sv
// DEPTH-entry FIFO of pending choice updates; head visible combinationally, 1-cycle push-to-pop.
// Caller guarantees no push when full and no pop when empty; simultaneous push/pop keeps count.
module choice_upd_fifo
    import choice_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  choice_upd_t                push_dat,
    input  logic                       pop,
    output choice_upd_t                pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    choice_upd_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/choice_update_scheduler.sv
// Arbitrates the single-ported choice table between lookups and queued updates; owns path history.
// Lookups granted same cycle unless the update queue is full; resolves refused while the queue is full.
module choice_update_scheduler
    import choice_update_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                      clock,
    input  logic                      reset,
    choice_update_scheduler_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [HIST_W-1:0] phist_q;
    logic [HIST_W-1:0] phist_d;
    choice_upd_t       push_dat;
    choice_upd_t       head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              accept;
    logic [CW-1:0]     count;

    choice_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // Ready comes from registered occupancy only, so a draining full queue still refuses.
    assign bus.resolve_ready = reset | ~full;
    assign accept            = bus.resolve_valid & bus.resolve_ready & ~reset;
    assign push              = accept & (bus.local_correct ^ bus.global_correct);
    assign push_dat.hist     = bus.resolve_hist;
    assign push_dat.dir      = bus.global_correct;

    // Full queue beats lookups so the resolve path can never deadlock.
    always_comb begin
        pop               = 1'b0;
        bus.tbl_en        = 1'b0;
        bus.tbl_we        = 1'b0;
        bus.tbl_addr      = head.hist;
        bus.tbl_favor_glb = head.dir;
        bus.lookup_ready  = 1'b0;
        if (!reset) begin
            if (full) begin
                pop        = 1'b1;
                bus.tbl_en = 1'b1;
                bus.tbl_we = 1'b1;
            end else if (bus.lookup_valid) begin
                bus.tbl_en       = 1'b1;
                bus.tbl_addr     = phist_q;
                bus.lookup_ready = 1'b1;
            end else if (!empty) begin
                pop        = 1'b1;
                bus.tbl_en = 1'b1;
                bus.tbl_we = 1'b1;
            end
        end
    end

    always_comb begin
        phist_d = phist_q;
        if (accept && bus.resolve_mispred) begin
            phist_d = {bus.resolve_hist[HIST_W-2:0], bus.resolve_taken};
        end else if (bus.lookup_ready) begin
            phist_d = {phist_q[HIST_W-2:0], bus.lookup_pred_tkn};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phist_q <= '0;
        end else begin
            phist_q <= phist_d;
        end
    end

    assign bus.phist       = phist_q;
    assign bus.lookup_hist = phist_q;
    assign bus.q_count     = count;

endmodule

// File: tb/tb_choice_update_scheduler.sv
// Bench for choice_update_scheduler: expected table accesses go into a queue, a monitor checks them.
module tb_choice_update_scheduler;
    import choice_update_scheduler_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    choice_update_scheduler_if #(.DEPTH(4)) bus();
    choice_update_scheduler #(.DEPTH(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        logic              we;
        logic [HIST_W-1:0] addr;
        logic              favor;
    } acc_t;

    acc_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_acc(input logic we, input logic [HIST_W-1:0] addr, input logic favor);
        acc_t a;
        a.we = we; a.addr = addr; a.favor = favor;
        exp_q.push_back(a);
    endtask

    task automatic idle();
        bus.lookup_valid    = 1'b0;
        bus.lookup_pred_tkn = 1'b0;
        bus.resolve_valid   = 1'b0;
        bus.resolve_hist    = '0;
        bus.resolve_taken   = 1'b0;
        bus.resolve_mispred = 1'b0;
        bus.local_correct   = 1'b0;
        bus.global_correct  = 1'b0;
    endtask

    task automatic lookup(input logic p);
        bus.lookup_valid    = 1'b1;
        bus.lookup_pred_tkn = p;
    endtask

    task automatic resolve(input logic [HIST_W-1:0] h, input logic t, input logic m,
                           input logic lc, input logic gc);
        bus.resolve_valid   = 1'b1;
        bus.resolve_hist    = h;
        bus.resolve_taken   = t;
        bus.resolve_mispred = m;
        bus.local_correct   = lc;
        bus.global_correct  = gc;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every table access must match the oldest expected one.
    always @(negedge clock) begin
        acc_t e;
        if (bus.tbl_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access actual we=%0b addr=%0h expected none at %0t",
                         bus.tbl_we, bus.tbl_addr, $time);
            end else begin
                e = exp_q.pop_front();
                chk("tbl_we", 32'(bus.tbl_we), 32'(e.we));
                chk("tbl_addr", 32'(bus.tbl_addr), 32'(e.addr));
                if (e.we) chk("tbl_favor_glb", 32'(bus.tbl_favor_glb), 32'(e.favor));
            end
        end else begin
            chk("tbl_we_idle", 32'(bus.tbl_we), 32'd0);
        end
    end

    initial begin
        logic [2:0]  p3;
        logic [11:0] la5 [4];
        logic [11:0] rh5 [4];
        logic [3:0]  rg5;
        logic [11:0] la6 [3];
        logic [11:0] rh6 [3];

        idle();
        reset = 1'b1;
        next_cycle();
        // Requests during reset must be ignored.
        lookup(1'b1);
        resolve(12'h0F0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        chk("rst_lookup_ready", 32'(bus.lookup_ready), 32'd0);
        chk("rst_resolve_ready", 32'(bus.resolve_ready), 32'd1);
        chk("rst_tbl_en", 32'(bus.tbl_en), 32'd0);
        next_cycle();
        reset = 1'b0;
        idle();
        @(negedge clock);
        chk("idle_phist", 32'(bus.phist), 32'h000);
        chk("idle_q_count", 32'(bus.q_count), 32'd0);
        chk("idle_resolve_ready", 32'(bus.resolve_ready), 32'd1);
        chk("idle_lookup_ready", 32'(bus.lookup_ready), 32'd0);
        next_cycle();

        // Lookups 1,0,1 from phist=0.
        p3 = 3'b101;
        for (int i = 0; i < 3; i++) begin
            lookup(p3[2-i]);
            expect_acc(1'b0, 12'(i), 1'b0);
            @(negedge clock);
            chk("lk_ready", 32'(bus.lookup_ready), 32'd1);
            chk("lk_hist", 32'(bus.lookup_hist), 32'(i));
            next_cycle();
        end
        idle();
        @(negedge clock);
        chk("phist_after_lookups", 32'(bus.phist), 32'h005);
        next_cycle();

        // Single disagreeing resolve drains in the next idle cycle.
        resolve(12'h0A5, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_acc(1'b1, 12'h0A5, 1'b0);
        @(negedge clock);
        chk("res_ready", 32'(bus.resolve_ready), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("q_count_one", 32'(bus.q_count), 32'd1);
        next_cycle();
        @(negedge clock);
        chk("q_count_drained", 32'(bus.q_count), 32'd0);
        next_cycle();

        // Agreeing resolve is dropped.
        resolve(12'h3C3, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        chk("agree_ready", 32'(bus.resolve_ready), 32'd1);
        next_cycle();
        idle();
        @(negedge clock);
        chk("agree_q_count", 32'(bus.q_count), 32'd0);
        next_cycle();
        next_cycle();

        // Continuous lookups fill the queue; full forces a write and blocks the lookup.
        la5 = '{12'h005, 12'h00A, 12'h014, 12'h028};
        rh5 = '{12'h101, 12'h102, 12'h103, 12'h104};
        rg5 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            lookup(1'b0);
            resolve(rh5[i], 1'b0, 1'b0, ~rg5[i], rg5[i]);
            expect_acc(1'b0, la5[i], 1'b0);
            @(negedge clock);
            chk("fill_lookup_ready", 32'(bus.lookup_ready), 32'd1);
            next_cycle();
        end
        lookup(1'b0);
        resolve(12'h1FF, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_acc(1'b1, 12'h101, 1'b1);
        @(negedge clock);
        chk("full_q_count", 32'(bus.q_count), 32'd4);
        chk("full_resolve_ready", 32'(bus.resolve_ready), 32'd0);
        chk("full_lookup_ready", 32'(bus.lookup_ready), 32'd0);
        chk("full_phist_hold", 32'(bus.phist), 32'h050);
        next_cycle();
        idle();
        lookup(1'b0);
        expect_acc(1'b0, 12'h050, 1'b0);
        @(negedge clock);
        chk("after_full_q_count", 32'(bus.q_count), 32'd3);
        chk("after_full_resolve_ready", 32'(bus.resolve_ready), 32'd1);
        chk("after_full_lookup_ready", 32'(bus.lookup_ready), 32'd1);
        next_cycle();
        idle();
        expect_acc(1'b1, 12'h102, 1'b0);
        expect_acc(1'b1, 12'h103, 1'b1);
        expect_acc(1'b1, 12'h104, 1'b0);
        repeat (3) next_cycle();
        @(negedge clock);
        chk("drain_q_count", 32'(bus.q_count), 32'd0);
        next_cycle();

        // Mispredict recovery beats the simultaneous lookup shift.
        lookup(1'b1);
        resolve(12'h7FF, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_acc(1'b0, 12'h0A0, 1'b0);
        next_cycle();
        idle();
        @(negedge clock);
        chk("recover_phist", 32'(bus.phist), 32'hFFE);
        next_cycle();

        // Queue three updates behind lookups, then reset discards them.
        la6 = '{12'hFFE, 12'hFFC, 12'hFF8};
        rh6 = '{12'h011, 12'h022, 12'h033};
        for (int i = 0; i < 3; i++) begin
            lookup(1'b0);
            resolve(rh6[i], 1'b0, 1'b0, 1'b0, 1'b1);
            expect_acc(1'b0, la6[i], 1'b0);
            next_cycle();
        end
        idle();
        reset = 1'b1;
        @(negedge clock);
        chk("pre_reset_q_count", 32'(bus.q_count), 32'd3);
        chk("mid_reset_tbl_en", 32'(bus.tbl_en), 32'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_q_count", 32'(bus.q_count), 32'd0);
        chk("post_reset_phist", 32'(bus.phist), 32'h000);
        repeat (4) next_cycle();
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
